// File: rtl/present_sbox_layer_seq.sv
// PRESENT S-box layer, applied LANES nibbles per clock over WIDTH/(4*LANES) cycles.
// Optional macro: PRESENT_SBOX_INV_EN adds the in_inv port and the inverse S-box.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_data is the state to substitute
//   in_inv               inverse S-box select (PRESENT_SBOX_INV_EN only)
//   out_valid/out_ready  output handshake; out_data is the substituted state
//   busy                 a block is being substituted or is waiting to be taken
module present_sbox_layer_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef PRESENT_SBOX_INV_EN
  input  logic             in_inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned NNIB = WIDTH / 4;
  localparam int unsigned NCYC = (LANES == 0) ? 1 : NNIB / LANES;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  // Reject illegal geometry at elaboration.
  if (LANES < 1) begin : g_bad_lanes
    $error("present_sbox_layer_seq: LANES must be >= 1");
  end else if ((WIDTH == 0) || ((WIDTH % (4 * LANES)) != 0)) begin : g_bad_width
    $error("present_sbox_layer_seq: WIDTH must be a nonzero multiple of 4*LANES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           st_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
`ifdef PRESENT_SBOX_INV_EN
  logic             inv_q;
`endif

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

`ifdef PRESENT_SBOX_INV_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction
`endif

  // Substitute only the nibble group selected by the cycle counter, lowest group first.
  always_comb begin
    state_d = state_q;
    for (int n = 0; n < int'(NNIB); n++) begin
      if (CW'(n / int'(LANES)) == cnt_q) begin
`ifdef PRESENT_SBOX_INV_EN
        state_d[n*4 +: 4] = inv_q ? sbox_inv(state_q[n*4 +: 4]) : sbox_fwd(state_q[n*4 +: 4]);
`else
        state_d[n*4 +: 4] = sbox_fwd(state_q[n*4 +: 4]);
`endif
      end
    end
  end

  // Control FSM; in_ready comes up on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      state_q   <= '0;
`ifdef PRESENT_SBOX_INV_EN
      inv_q     <= 1'b0;
`endif
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state_q  <= in_data;
`ifdef PRESENT_SBOX_INV_EN
            inv_q    <= in_inv;
`endif
            cnt_q    <= '0;
            st_q     <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          state_q <= state_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NCYC - 1)) begin
            cnt_q     <= '0;
            st_q      <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q      <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          st_q      <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = state_q;

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Directed bench for present_sbox_layer_seq: a LANES=4 instance and a LANES=16 instance.
module tb_present_sbox_layer_seq;

  logic        clk;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [63:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [63:0] b_in_data, b_out_data;
`ifdef PRESENT_SBOX_INV_EN
  logic        a_in_inv, b_in_inv;
`endif

  int errors;
  int checks;

  present_sbox_layer_seq #(.WIDTH(64), .LANES(4)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
`ifdef PRESENT_SBOX_INV_EN
    .in_inv    (a_in_inv),
`endif
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .busy      (a_busy)
  );

  present_sbox_layer_seq #(.WIDTH(64), .LANES(16)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
`ifdef PRESENT_SBOX_INV_EN
    .in_inv    (b_in_inv),
`endif
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
`ifdef PRESENT_SBOX_INV_EN
    a_in_inv = 1'b0; b_in_inv = 1'b0;
`endif

    // Reset state.
    #3;
    chk("rst_in_ready",  64'(a_in_ready),  64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_busy",      64'(a_busy),      64'd0);
    chk("rst_out_data",  a_out_data,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 64'(a_in_ready), 64'd1);

    // Block 1: reference vector, 4-cycle latency, lowest group first.
    a_in_valid = 1'b1;
    a_in_data  = 64'h0123456789ABCDEF;
    a_out_ready = 1'b1;
    step();
    chk("b1_in_ready_run", 64'(a_in_ready), 64'd0);
    chk("b1_busy_run",     64'(a_busy),     64'd1);
    a_in_valid = 1'b0;
    a_in_data  = 64'hDEADBEEFDEADBEEF;
    step();
    chk("b1_group0_first", a_out_data, 64'h0123456789AB4712);
    step();
    step();
    chk("b1_no_early_valid", 64'(a_out_valid), 64'd0);
    step();
    chk("b1_valid_at_4", 64'(a_out_valid), 64'd1);
    chk("b1_data",       a_out_data,       64'hC56B90AD3EF84712);
    chk("b1_in_ready_done", 64'(a_in_ready), 64'd0);
    step();
    chk("b1_valid_drop",  64'(a_out_valid), 64'd0);
    chk("b1_idle_ready",  64'(a_in_ready),  64'd1);
    chk("b1_idle_busy",   64'(a_busy),      64'd0);

    // Block 2: all zeros, held in DONE under back-pressure; in_valid ignored.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 64'h0;
    step();
    a_in_data = 64'h1111111111111111;
    repeat (4) step();
    chk("b2_valid", 64'(a_out_valid), 64'd1);
    chk("b2_data",  a_out_data,       64'hCCCCCCCCCCCCCCCC);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("b2_hold_valid_%0d", i), 64'(a_out_valid), 64'd1);
      chk($sformatf("b2_hold_data_%0d", i),  a_out_data,       64'hCCCCCCCCCCCCCCCC);
      chk($sformatf("b2_hold_ready_%0d", i), 64'(a_in_ready),  64'd0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    chk("b2_release", 64'(a_out_valid), 64'd0);

    // Block 3: reset during RUN discards the block.
    a_in_valid = 1'b1;
    a_in_data  = 64'h0123456789ABCDEF;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_run_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_run_busy",      64'(a_busy),      64'd0);
    chk("rst_run_out_data",  a_out_data,       64'd0);
    chk("rst_run_in_ready",  64'(a_in_ready),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rst_no_stale_valid_%0d", i), 64'(a_out_valid), 64'd0);
    end

    // Block 4: all ones after reset.
    a_in_valid = 1'b1;
    a_in_data  = 64'hFFFFFFFFFFFFFFFF;
    step();
    a_in_valid = 1'b0;
    repeat (4) step();
    chk("b4_valid", 64'(a_out_valid), 64'd1);
    chk("b4_data",  a_out_data,       64'h2222222222222222);
    step();

`ifdef PRESENT_SBOX_INV_EN
    // Block 5: inverse S-box latched at acceptance, toggling in_inv afterwards has no effect.
    a_in_valid = 1'b1;
    a_in_inv   = 1'b1;
    a_in_data  = 64'hC56B90AD3EF84712;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_inv = ~a_in_inv;
      step();
    end
    chk("inv_valid", 64'(a_out_valid), 64'd1);
    chk("inv_data",  a_out_data,       64'h0123456789ABCDEF);
    step();
    a_in_inv = 1'b0;
`endif

    // LANES=16: single-cycle substitution.
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 64'h0123456789ABCDEF;
    step();
    b_in_valid = 1'b0;
    chk("l16_run_valid", 64'(b_out_valid), 64'd0);
    step();
    chk("l16_valid", 64'(b_out_valid), 64'd1);
    chk("l16_data",  b_out_data,       64'hC56B90AD3EF84712);
    b_out_ready = 1'b1;
    step();
    chk("l16_idle_ready", 64'(b_in_ready), 64'd1);

    // LANES=16 back-to-back: one acceptance every third cycle.
    b_in_valid = 1'b1;
    b_in_data  = 64'h0000000000000000;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("l16_b2b_ready_%0d", i), 64'(b_in_ready),  64'((i % 3) == 2));
      chk($sformatf("l16_b2b_valid_%0d", i), 64'(b_out_valid), 64'((i % 3) == 1));
      if ((i % 3) == 1)
        chk($sformatf("l16_b2b_data_%0d", i), b_out_data, 64'hCCCCCCCCCCCCCCCC);
    end
    b_in_valid = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/present_sbox_layer_seq.md
PRESENT_SBOX_LAYER_SEQ -- requirements
Module: present_sbox_layer_seq

Interface
REQ-001 Parameter WIDTH, default 64, state width in bits; SHALL be a multiple of 4*LANES.
REQ-002 Parameter LANES, default 4, PRESENT S-boxes applied per clock cycle; SHALL be ≥1 and divide WIDTH/4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data (and in_inv when present) valid.
REQ-006 in_ready  output  1  block can accept a new state.
REQ-007 in_data  input  WIDTH  state to substitute.
REQ-008 in_inv  input  1  select inverse S-box; the port SHALL exist only when PRESENT_SBOX_INV_EN is defined.
REQ-009 out_valid  output  1  out_data holds a completed result.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  WIDTH  substituted state.
REQ-012 busy  output  1  high in RUN and DONE.

Function
REQ-013 Forward S-box, nibble 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-014 NCYC = WIDTH/(4*LANES); a cycle counter of ceil(log2(NCYC)) bits (min 1) SHALL index nibble groups.
REQ-015 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid&&in_ready, register in_data (and in_inv), clear counter, go to RUN; otherwise stay in IDLE.
REQ-017 RUN, cycle c: replace nibbles c*LANES .. c*LANES+LANES-1 (nibble n = bits 4n+3:4n, lowest first) with their S-box images; increment counter.
REQ-018 RUN with c = NCYC-1: perform the final substitution, go to DONE; each nibble SHALL be substituted exactly once.
REQ-019 Latency: out_valid SHALL rise exactly NCYC cycles after the accepting edge; with NCYC=1, the block SHALL go IDLE->RUN->DONE.
REQ-020 DONE: out_data SHALL hold stable while out_ready=0; on out_ready=1, go to IDLE; in_ready SHALL not assert in the same cycle as out_valid.
REQ-021 out_data SHALL always reflect the internal state register; its value is defined only while out_valid=1.
REQ-022 in_valid in RUN/DONE SHALL be ignored; the in_data value captured at acceptance SHALL NOT be affected by later input changes.
REQ-023 Parameter violations of REQ-001/002 SHALL fail elaboration.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, counter=0, state register=0, and latched inv=0, giving in_ready=1 only once rst_n deasserts, out_valid=0, busy=0, out_data=0.
REQ-025 Reset in RUN or DONE SHALL discard the in-flight block; no out_valid for it SHALL follow.

Configuration
REQ-026 Macro PRESENT_SBOX_INV_EN defined: in_inv SHALL exist and be latched at acceptance; inv=1 SHALL select the inverse S-box, nibble 0..F -> 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A, for the whole block.
REQ-027 Macro not defined: no in_inv port and no inverse table logic; forward S-box SHALL always be used.

Verification
REQ-028 WIDTH=64, LANES=4, in_data=0x0123456789ABCDEF -> out_data=0xC56B90AD3EF84712, with out_valid rising 4 cycles after acceptance.
REQ-029 in_data=0x0000000000000000 -> 0xCCCCCCCCCCCCCCCC; hold out_ready=0 for 5 cycles -> out_valid and out_data remain stable, in_ready=0 throughout.
REQ-030 Assert rst_n=0 on RUN cycle 2 -> out_valid=0, busy=0, out_data=0 at once; a subsequent 0xFFFFFFFFFFFFFFFF block -> 0x2222222222222222.
REQ-031 With PRESENT_SBOX_INV_EN defined, in_inv=1, in_data=0xC56B90AD3EF84712 -> 0x0123456789ABCDEF; in_inv toggled during RUN -> result unchanged.
REQ-032 WIDTH=64, LANES=16 -> 0x0123456789ABCDEF yields 0xC56B90AD3EF84712 one cycle after acceptance; back-to-back blocks with out_ready=1 accept every 3rd cycle.
